// File: rtl/vec_lane_collector_pkg.sv
// vec_pkg: shared types and sizing helpers
// for the vector lane collector.
package vec_pkg;

  localparam logic [2:0] VSEW_8  = 3'd0;
  localparam logic [2:0] VSEW_16 = 3'd1;
  localparam logic [2:0] VSEW_32 = 3'd2;
  localparam logic [2:0] VSEW_64 = 3'd3;

  localparam int REG_INDEX_W = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic int chunk_log2(
    input logic [2:0] vsew,
    input int         lane_width
  );
    int l;
    l = int'(vsew) + 3;
    return (l < lane_width) ? l : lane_width;
  endfunction

  function automatic int run_cycles(
    input int         vlen,
    input logic [2:0] vsew,
    input int         lane_width,
    input int         nb_lanes
  );
    return (vlen >> chunk_log2(vsew, lane_width)) >> nb_lanes;
  endfunction

endpackage

// File: rtl/vec_lane_collector_if.sv
// vec_lane_collector_if: op request and result
// writeback handshakes of the lane collector.
interface vec_lane_collector_if #(
  parameter int VLEN = 128
) ();

  logic            req_valid;
  logic            req_ready;
  logic [5:0]      req_opcode;
  logic [2:0]      req_vsew;
  logic [VLEN-1:0] req_vs1;
  logic [VLEN-1:0] req_vs2;
  logic            res_valid;
  logic            res_ready;
  logic [VLEN-1:0] res_vd;
  logic            res_err;

  modport master (
    output req_valid, req_opcode, req_vsew,
    output req_vs1, req_vs2, res_ready,
    input  req_ready, res_valid, res_vd, res_err
  );

  modport slave (
    input  req_valid, req_opcode, req_vsew,
    input  req_vs1, req_vs2, res_ready,
    output req_ready, res_valid, res_vd, res_err
  );

endinterface

// File: rtl/vec_slice_merge.sv
// vec_slice_merge: inserts one lane's chunk at its
// bit offset, masking writes that run past VLEN.
module vec_slice_merge #(
  parameter int VLEN = 128,
  parameter int IW   = 10
) (
  input  logic [VLEN-1:0] acc_in,
  input  logic [VLEN-1:0] vd,
  input  logic [IW-1:0]   reg_index,
  input  logic [3:0]      chunk_lg,
  output logic [VLEN-1:0] acc_out,
  output logic            oor
);

  localparam int EW = IW + 1;

  logic [EW-1:0]   chunk;
  logic [EW-1:0]   top;
  logic [VLEN-1:0] mask;

  // masked insert of chunk bits at reg_index
  always_comb begin
    chunk = EW'(1) << chunk_lg;
    top   = {1'b0, reg_index} + chunk;
    oor   = top > EW'(VLEN);
    mask  = ~({VLEN{1'b1}} << chunk) << reg_index;
    if (oor) begin
      acc_out = acc_in;
    end else begin
      acc_out = (acc_in & ~mask) | (vd & mask);
    end
  end

endmodule

// File: rtl/vec_lane_collector.sv
// vec_lane_collector: issues one vector op to the lane
// array and assembles the lane slices into vd.
module vec_lane_collector
  import vec_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4,
  parameter int NB_LANES   = 1
) (
  input  logic clk,
  input  logic resetn,
  vec_lane_collector_if.slave io,
  output logic lane_run,
  output logic [5:0] lane_opcode,
  output logic [2:0] lane_vsew,
  output logic [VLEN-1:0] lane_vs1,
  output logic [VLEN-1:0] lane_vs2,
  input  logic [(VLEN<<NB_LANES)-1:0] lane_vd,
  input  logic [(REG_INDEX_W<<NB_LANES)-1:0] lane_reg_index,
  input  logic [(1<<NB_LANES)-1:0] lane_done
);

  localparam int NL = 1 << NB_LANES;
  localparam int CW = $clog2(VLEN + 1);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   last;
  logic            cap_en;
  logic            bad;
  logic [3:0]      clg;
  logic [VLEN-1:0] res_q;
  logic            err_q;
  logic [VLEN-1:0] merged;
  logic [NL-1:0]   oor;

  assign bad  = lane_vsew > VSEW_64;
  assign clg  = 4'(chunk_log2(lane_vsew, LANE_WIDTH));
  assign last = CW'(run_cycles(VLEN, lane_vsew,
                    LANE_WIDTH, NB_LANES) - 1);

  assign io.req_ready = state == IDLE;
  assign io.res_valid = state == DONE;
  assign io.res_vd    = res_q;
  assign io.res_err   = err_q;
  assign lane_run     = (state == RUN) ||
                        (state == DRAIN && !bad);

  // chain of merges; higher lanes land last and win
  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic [VLEN-1:0] a_in;
    logic [VLEN-1:0] a_out;
    if (i == 0) begin : g_first
      assign a_in = res_q;
    end else begin : g_next
      assign a_in = g_lane[i-1].a_out;
    end
    vec_slice_merge #(
      .VLEN (VLEN),
      .IW   (REG_INDEX_W)
    ) u_merge (
      .acc_in    (a_in),
      .vd        (lane_vd[i*VLEN +: VLEN]),
      .reg_index (lane_reg_index[i*REG_INDEX_W +: REG_INDEX_W]),
      .chunk_lg  (clg),
      .acc_out   (a_out),
      .oor       (oor[i])
    );
  end

  assign merged = g_lane[NL-1].a_out;

  // sequencer: latch op, arm lanes, run N cycles, drain
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      lane_opcode <= '0;
      lane_vsew   <= '0;
      lane_vs1    <= '0;
      lane_vs2    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.req_valid) begin
            lane_opcode <= io.req_opcode;
            lane_vsew   <= io.req_vsew;
            lane_vs1    <= io.req_vs1;
            lane_vs2    <= io.req_vs2;
            state       <= ARM;
          end
        end
        ARM: begin
          cnt   <= '0;
          state <= bad ? DRAIN : RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == last) state <= DRAIN;
        end
        DRAIN: state <= DONE;
        DONE: begin
          if (io.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // capture strobe trails RUN by one lane latency
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cap_en <= 1'b0;
    else         cap_en <= state == RUN;
  end

  // result assembly and done/range error tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_q <= '0;
      err_q <= 1'b0;
    end else if (state == IDLE && io.req_valid) begin
      res_q <= '0;
      err_q <= io.req_vsew > VSEW_64;
    end else if (cap_en) begin
      res_q <= merged;
      if (|oor) err_q <= 1'b1;
      if (state == RUN && |lane_done) err_q <= 1'b1;
      if (state == DRAIN && !(&lane_done)) err_q <= 1'b1;
    end
  end

endmodule
